// File: rtl/huffman_act_serializer.sv
// Word-to-bit serializer feeding the activation Huffman decoder, MSB first, with a one-word
// holding buffer for gap-free output. Optional last-word/partial-length support: HUFF_SER_LAST_EN.
module huffman_act_serializer #(
    parameter int unsigned WORD_W = 32,
    parameter int unsigned CNT_W  = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [WORD_W-1:0] word_in,
    input  logic              word_valid,
    output logic              word_ready,
    output logic              out_bit,
    output logic              out_valid,
    input  logic              out_ready
`ifdef HUFF_SER_LAST_EN
    ,
    input  logic              word_last,
    input  logic [CNT_W:0]    word_nbits,
    output logic              done
`endif
);

    logic [WORD_W-1:0] sh_q, sh_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              act_v_q, act_v_d;
    logic [WORD_W-1:0] hd_q, hd_d;
    logic [CNT_W-1:0]  hd_cnt_q, hd_cnt_d;
    logic              hold_v_q, hold_v_d;

    logic              accept, fire, last;
    logic              load_in, load_hd, drop, shift, hold_wr;
    logic [CNT_W-1:0]  in_cnt;

    assign word_ready = reset & ~hold_v_q;
    assign out_valid  = reset & act_v_q;
    assign out_bit    = reset & sh_q[WORD_W-1];

    assign accept = word_valid & word_ready;
    assign fire   = out_valid & out_ready;
    assign last   = fire & (cnt_q == '0);

    // Mutually exclusive update actions; accept implies an empty hold.
    assign load_in = accept & (~act_v_q | (last & ~hold_v_q));
    assign load_hd = last & hold_v_q;
    assign drop    = last & ~hold_v_q & ~accept;
    assign shift   = fire & ~last;
    assign hold_wr = act_v_q & ~last & accept;

`ifdef HUFF_SER_LAST_EN
    logic [CNT_W:0] nbits_m1;
    // nbits of 0 or WORD_W both wrap to WORD_W-1 in the low CNT_W bits.
    assign nbits_m1 = word_nbits - 1'b1;
    assign in_cnt   = word_last ? nbits_m1[CNT_W-1:0] : CNT_W'(WORD_W - 1);
`else
    assign in_cnt = CNT_W'(WORD_W - 1);
`endif

    always_comb begin
        sh_d     = sh_q;
        cnt_d    = cnt_q;
        act_v_d  = act_v_q;
        hd_d     = hd_q;
        hd_cnt_d = hd_cnt_q;
        hold_v_d = hold_v_q;

        if (load_in) begin
            sh_d    = word_in;
            cnt_d   = in_cnt;
            act_v_d = 1'b1;
        end else if (load_hd) begin
            sh_d     = hd_q;
            cnt_d    = hd_cnt_q;
            act_v_d  = 1'b1;
            hold_v_d = 1'b0;
        end else if (drop) begin
            sh_d    = '0;
            cnt_d   = '0;
            act_v_d = 1'b0;
        end else if (shift) begin
            sh_d  = sh_q << 1;
            cnt_d = cnt_q - 1'b1;
        end

        if (hold_wr) begin
            hd_d     = word_in;
            hd_cnt_d = in_cnt;
            hold_v_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            sh_q     <= '0;
            cnt_q    <= '0;
            act_v_q  <= 1'b0;
            hd_q     <= '0;
            hd_cnt_q <= '0;
            hold_v_q <= 1'b0;
        end else begin
            sh_q     <= sh_d;
            cnt_q    <= cnt_d;
            act_v_q  <= act_v_d;
            hd_q     <= hd_d;
            hd_cnt_q <= hd_cnt_d;
            hold_v_q <= hold_v_d;
        end
    end

`ifdef HUFF_SER_LAST_EN
    logic act_last_q, act_last_d;
    logic hd_last_q, hd_last_d;
    logic done_q, done_d;

    always_comb begin
        act_last_d = act_last_q;
        hd_last_d  = hd_last_q;
        done_d     = last & act_last_q;
        if (load_in) begin
            act_last_d = word_last;
        end else if (load_hd) begin
            act_last_d = hd_last_q;
        end else if (drop) begin
            act_last_d = 1'b0;
        end
        if (hold_wr) begin
            hd_last_d = word_last;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            act_last_q <= 1'b0;
            hd_last_q  <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            act_last_q <= act_last_d;
            hd_last_q  <= hd_last_d;
            done_q     <= done_d;
        end
    end

    assign done = done_q;
`endif

endmodule

// File: tb/tb_huffman_act_serializer.sv
// Scoreboard bench for huffman_act_serializer: expected bits are queued on word acceptance
// and compared on every output fire.
module tb_huffman_act_serializer;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned CNT_W  = 5;

    typedef struct packed {
        logic b;
        logic fin;
    } exp_t;

    logic              clk;
    logic              reset;
    logic [WORD_W-1:0] word_in;
    logic              word_valid;
    logic              word_ready;
    logic              out_bit;
    logic              out_valid;
    logic              out_ready;
`ifdef HUFF_SER_LAST_EN
    logic              word_last;
    logic [CNT_W:0]    word_nbits;
    logic              done;
`endif

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t exp_q[$];

    int   n_fire, ready_low, valid_run, max_run, done_cnt;
    logic prev_or, prev_ov, prev_ob, prev_rst;
    logic done_exp;

    huffman_act_serializer #(
        .WORD_W(WORD_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .word_in   (word_in),
        .word_valid(word_valid),
        .word_ready(word_ready),
        .out_bit   (out_bit),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef HUFF_SER_LAST_EN
        ,
        .word_last (word_last),
        .word_nbits(word_nbits),
        .done      (done)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Monitor: sampled on the falling edge, i.e. the values the next rising edge will act on.
    always @(negedge clk) begin
        exp_t e;
        int   nb;
        if (!reset) begin
            exp_q.delete();
        end else begin
`ifdef HUFF_SER_LAST_EN
            check_eq("done_pulse", {31'd0, done}, {31'd0, done_exp});
            if (done) done_cnt++;
            done_exp = 1'b0;
`endif
            if (prev_rst && !prev_or && prev_ov) begin
                check_eq("stall_valid", {31'd0, out_valid}, {31'd0, prev_ov});
                check_eq("stall_bit", {31'd0, out_bit}, {31'd0, prev_ob});
            end
            if (out_valid && out_ready) begin
                n_fire++;
                if (exp_q.size() == 0) begin
                    check_eq("extra_bit", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check_eq("stream_bit", {31'd0, out_bit}, {31'd0, e.b});
`ifdef HUFF_SER_LAST_EN
                    done_exp = e.fin;
`endif
                end
            end
            if (word_valid && word_ready) begin
                nb = WORD_W;
`ifdef HUFF_SER_LAST_EN
                if (word_last && word_nbits != 0) nb = int'(word_nbits);
`endif
                for (int i = 0; i < nb; i++) begin
                    e.b   = word_in[WORD_W-1-i];
                    e.fin = 1'b0;
`ifdef HUFF_SER_LAST_EN
                    e.fin = word_last && (i == nb - 1);
`endif
                    exp_q.push_back(e);
                end
            end
            if (!word_ready) ready_low++;
            if (out_valid) begin
                valid_run++;
                if (valid_run > max_run) max_run = valid_run;
            end else begin
                valid_run = 0;
            end
        end
        prev_or  = out_ready;
        prev_ov  = out_valid;
        prev_ob  = out_bit;
        prev_rst = reset;
    end

    task automatic clear_stats();
        n_fire    = 0;
        ready_low = 0;
        valid_run = 0;
        max_run   = 0;
        done_cnt  = 0;
    endtask

    task automatic send_word(input logic [WORD_W-1:0] w);
        logic acc;
        acc        = 1'b0;
        word_in    = w;
        word_valid = 1'b1;
        for (int c = 0; c < 200 && !acc; c++) begin
            @(negedge clk);
            acc = word_ready;
            @(posedge clk);
            #1;
        end
        if (!acc) check_eq("accept_timeout", 32'd1, 32'd0);
        word_valid = 1'b0;
    endtask

    task automatic drain(input bit toggle_ready);
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < 400 && !ok; c++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !out_valid) ok = 1'b1;
            @(posedge clk);
            #1;
            if (toggle_ready) out_ready = ~out_ready;
        end
        if (!ok) check_eq("drain_timeout", 32'd1, 32'd0);
        out_ready = 1'b1;
    endtask

    initial begin
        logic [WORD_W-1:0] words[3];
        int                idx;
        logic              acc;

        reset      = 1'b0;
        word_in    = '0;
        word_valid = 1'b0;
        out_ready  = 1'b1;
        done_exp   = 1'b0;
        prev_rst   = 1'b0;
        prev_or    = 1'b1;
        prev_ov    = 1'b0;
        prev_ob    = 1'b0;
`ifdef HUFF_SER_LAST_EN
        word_last  = 1'b0;
        word_nbits = '0;
`endif
        clear_stats();

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_word_ready", {31'd0, word_ready}, 32'd0);
        check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check_eq("rst_out_bit", {31'd0, out_bit}, 32'd0);
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        check_eq("idle_word_ready", {31'd0, word_ready}, 32'd1);
        check_eq("idle_out_valid", {31'd0, out_valid}, 32'd0);
        @(posedge clk);
        #1;

        // Single word, latency and full drain.
        clear_stats();
        send_word(32'hA500_0001);
        @(negedge clk);
        check_eq("first_bit_latency", {31'd0, out_valid}, 32'd1);
        check_eq("first_bit_value", {31'd0, out_bit}, 32'd1);
        @(posedge clk);
        #1;
        drain(1'b0);
        check_eq("single_fires", n_fire, 32);
        check_eq("single_run", max_run, 32);

        // Back-to-back: three words with word_valid held high.
        clear_stats();
        words[0]   = 32'hDEAD_BEEF;
        words[1]   = 32'h0123_4567;
        words[2]   = 32'h8000_0001;
        idx        = 0;
        word_in    = words[0];
        word_valid = 1'b1;
        for (int c = 0; c < 300 && idx < 3; c++) begin
            @(negedge clk);
            acc = word_ready;
            @(posedge clk);
            #1;
            if (acc) begin
                idx++;
                if (idx == 3) word_valid = 1'b0;
                else word_in = words[idx];
            end
        end
        word_valid = 1'b0;
        check_eq("b2b_accepted", idx, 3);
        drain(1'b0);
        check_eq("b2b_fires", n_fire, 96);
        check_eq("b2b_no_gap", max_run, 96);
        check_eq("b2b_ready_low", ready_low, 62);

        // Backpressure with out_ready toggling every cycle.
        clear_stats();
        send_word(32'hF0F0_F0F0);
        out_ready = 1'b0;
        drain(1'b1);
        check_eq("bp_fires", n_fire, 32);

        // Reset in the middle of a word.
        clear_stats();
        word_in    = 32'hFFFF_FFFF;
        word_valid = 1'b1;
        @(posedge clk);
        #1 word_valid = 1'b0;
        for (int c = 0; c < 50 && n_fire < 10; c++) begin
            @(posedge clk);
            #1;
        end
        check_eq("mid_fires", n_fire, 10);
        reset = 1'b0;
        @(negedge clk);
        check_eq("mid_rst_ready", {31'd0, word_ready}, 32'd0);
        check_eq("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        check_eq("mid_rst_valid2", {31'd0, out_valid}, 32'd0);
        check_eq("mid_rst_bit", {31'd0, out_bit}, 32'd0);
        @(posedge clk);
        #1 reset = 1'b1;
        clear_stats();
        @(negedge clk);
        check_eq("post_rst_ready", {31'd0, word_ready}, 32'd1);
        check_eq("post_rst_valid", {31'd0, out_valid}, 32'd0);
        repeat (40) @(posedge clk);
        check_eq("post_rst_residue", n_fire, 0);
        #1;

`ifdef HUFF_SER_LAST_EN
        // Partial last word, then a full-length last word.
        clear_stats();
        word_last  = 1'b1;
        word_nbits = 6'd5;
        send_word(32'hF800_0000);
        word_last = 1'b0;
        drain(1'b0);
        repeat (2) @(posedge clk);
        #1;
        check_eq("last5_fires", n_fire, 5);
        check_eq("last5_done", done_cnt, 1);

        clear_stats();
        word_last  = 1'b1;
        word_nbits = 6'd0;
        send_word(32'h1234_5678);
        word_last = 1'b0;
        drain(1'b0);
        repeat (2) @(posedge clk);
        #1;
        check_eq("last32_fires", n_fire, 32);
        check_eq("last32_done", done_cnt, 1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/huffman_act_serializer.md
# huffman_act_serializer

Upstream feeder for the activation Huffman decoder (`huffman_act`). It accepts 32-bit compressed stream words from the activation SRAM/FIFO over a valid/ready handshake. It then shifts them out one bit per cycle, MSB first, as the decoder's bit-serial `in`/`valid_in`. A two-entry buffer (active shift register plus one holding register) sustains one bit per cycle with no bubble across word boundaries.

## Interface
- `WORD_W`, 32, compressed stream word width.
- `CNT_W`, 5, bit-counter width; equals log2(`WORD_W`).

- `clk`  in  1  single clock; all state updates on posedge.
- `reset`  in  1  synchronous, active-low reset.
- `word_in`  in  `WORD_W`  compressed word; bit `WORD_W-1` is sent first.
- `word_valid`  in  1  `word_in` is presented.
- `word_ready`  out  1  block can accept a word this cycle.
- `out_bit`  out  1  current stream bit; drives decoder `in`.
- `out_valid`  out  1  `out_bit` is meaningful; drives decoder `valid_in`.
- `out_ready`  in  1  downstream consumes `out_bit` this cycle; tie high if unused.
- `word_last`  in  1  (`HUFF_SER_LAST_EN` only) `word_in` is the final, possibly partial, word.
- `word_nbits`  in  `CNT_W+1`  (`HUFF_SER_LAST_EN` only) number of valid bits in the last word, 1..32; value 0 means 32.
- `done`  out  1  (`HUFF_SER_LAST_EN` only) one-cycle pulse after the final bit of a last word.

## Operation
- State:
  - active: shift register `sh`, remaining-bit counter `cnt` (bits left minus 1), flag `act_v`.
  - hold: register `hd`, flag `hold_v`.
- Invariant: `hold_v` implies `act_v`.
- Derived signals:
  - `accept = word_valid & word_ready`
  - `fire = out_valid & out_ready`
  - `last = fire & (cnt == 0)`
- Outputs:
  - `word_ready = reset & !hold_v`. It depends on state only, with no combinational path from `out_ready`.
  - `out_valid = act_v`.
  - `out_bit = sh[WORD_W-1]`.
- Active-register update, first matching rule wins:
  - `!act_v & accept`: load `sh <= word_in`, `cnt <= WORD_W-1`, `act_v <= 1`.
  - `last & hold_v`: load active from `hd`, `hold_v <= 0`. No accept is possible in this case because `word_ready` is 0.
  - `last & !hold_v & accept`: load active directly from `word_in` (bypass); hold stays empty.
  - `last` alone: `act_v <= 0`, `sh <= 0`.
  - `fire` (not last): `sh <= sh << 1`, `cnt <= cnt - 1`.
- Hold-register update: `act_v & !last & accept` → `hd <= word_in`, `hold_v <= 1`.
- `accept` and `fire` may occur in the same cycle. Both take effect per the rules above.
- Stall: while `out_ready = 0`, `sh`, `cnt`, `out_bit` and `out_valid` hold their values.

## Timing
- Reset (`reset = 0` at posedge) clears everything: `act_v = 0`, `hold_v = 0`, `sh = 0`, `cnt = 0`, `done = 0`.
  - While `reset` is low: `word_ready = 0`, `out_valid = 0`, `out_bit = 0`.
  - Reset mid-word discards all buffered bits. There is no partial flush.
- Latency: a word accepted at edge N presents its first bit with `out_valid = 1` in cycle N+1 when active was empty.
- Throughput: 1 bit/cycle. No bubble at word boundaries, provided the next word is in hold or is presented in the cycle of the current word's last bit.
- Buffer full: `word_ready` is low for exactly the cycles where `hold_v = 1`.
- `cnt` wraps only via reload; it never decrements below 0.

## Configuration
- `HUFF_SER_LAST_EN` defined:
  - Adds ports `word_last`, `word_nbits` and `done`.
  - Hold also stores `last` and `nbits`.
  - Loading a last word sets `cnt <= nbits - 1` (31 if `nbits = 0`), so only the top `nbits` bits are emitted.
  - `done` is registered and pulses high for one cycle in the cycle after the `last` fire of a last word.
  - The block keeps accepting words after a last word; the next stream starts normally.
- `HUFF_SER_LAST_EN` undefined: those ports are absent, every word emits all 32 bits, and there is no `done`.

## Test plan
- Single word with `out_ready = 1`: reset, then `word_in = 0xA5000001` → from the next cycle, 32 consecutive valid bits 1,0,1,0,0,1,0,1, 23×0, 1; then `out_valid = 0`.
- Back-to-back: 3 words with `word_valid` held high → 96 consecutive valid cycles with no gap; `word_ready` is low while hold is full; word order is preserved.
- Backpressure: `out_ready` toggling 1,0,1,0 over `0xF0F0F0F0` → `out_bit`/`out_valid` stable during 0 cycles; exactly 32 fires; sequence intact.
- Reset mid-word: reset low after 10 bits of `0xFFFFFFFF` → the cycle after, `out_valid = 0`, and `word_ready = 0` while low. After release, `word_ready = 1` and no residual bits appear.
- Chained with `huffman_act`: `0xFF000000` followed by zero-fill → decoder emits `valid` with `out = 0x00000000` (eight zero codes) after the 8th bit.
- `HUFF_SER_LAST_EN`:
  - `0xF8000000` with `word_last = 1`, `nbits = 5` → exactly 5 valid 1-bits, and `done` pulses in the cycle after the 5th fire.
  - `nbits = 0` → 32 bits, then `done`.
